// File: rtl/cube_frame_streamer.sv
`timescale 1ns/1ps
// cube_frame_streamer
//   Streams one LED-cube frame from the frame-buffer RAM to a byte-serial
//   UART transmitter: a SYNC_BYTE header followed by DEPTH data bytes in
//   address order. Supports single-shot and continuous operation.
//
//   Optional build macro CUBE_STREAM_CHECKSUM_EN: appends one byte holding
//   the modulo-256 sum of the DEPTH data bytes after the last data byte.
//
// Ports:
//   clock       system clock
//   resetn      synchronous reset, active-low
//   start       level, sampled in IDLE; launches a frame
//   continuous  sampled at DONE; 1 re-launches the next frame immediately
//   mem_addr    RAM read address (holds its value outside FETCH)
//   mem_q       RAM read data, valid RD_LAT clocks after mem_addr settles
//   tx_start    one-cycle send request to the UART
//   tx_byte     byte to send, stable from tx_start until tx_busy falls
//   tx_busy     UART is transmitting
//   busy        high in every state except IDLE
//   done        one-cycle pulse after the last byte of a frame completes
//   frame_cnt   completed-frame counter, wraps at 16'hFFFF
module cube_frame_streamer #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned RD_LAT    = 1,
  parameter logic [7:0]  SYNC_BYTE = 8'hF0
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              continuous,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_q,
  output logic              tx_start,
  output logic [7:0]        tx_byte,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_FETCH,
    S_SEND,
    S_ACK,
    S_DRAIN,
    S_DONE
`ifdef CUBE_STREAM_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  // idx is one bit wider than the address so DEPTH == 2**ADDR_W fits.
  localparam logic [ADDR_W:0] LAST_IDX   = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [1:0]      FETCH_LAST = 2'(RD_LAT - 1);

  state_t              r_state;
  logic [ADDR_W:0]     r_idx;
  logic [1:0]          r_fcnt;
  logic [1:0]          r_wait;
  logic                r_retried;
  logic                r_is_hdr;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_tx_start;
  logic [7:0]          r_tx_byte;
  logic                r_busy;
  logic                r_done;
  logic [15:0]         r_frame_cnt;
`ifdef CUBE_STREAM_CHECKSUM_EN
  logic [7:0]          r_sum;
  logic                r_is_csum;
`endif

  logic [ADDR_W:0]     w_idx_inc;

  assign w_idx_inc = r_idx + (ADDR_W+1)'(1);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_fcnt      <= '0;
      r_wait      <= '0;
      r_retried   <= 1'b0;
      r_is_hdr    <= 1'b0;
      r_mem_addr  <= '0;
      r_tx_start  <= 1'b0;
      r_tx_byte   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= '0;
`ifdef CUBE_STREAM_CHECKSUM_EN
      r_sum       <= '0;
      r_is_csum   <= 1'b0;
`endif
    end else begin
      r_tx_start <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy  <= 1'b1;
            r_state <= S_HDR;
          end
        end

        S_HDR: begin
          r_tx_byte <= SYNC_BYTE;
          r_idx     <= '0;
          r_is_hdr  <= 1'b1;
`ifdef CUBE_STREAM_CHECKSUM_EN
          r_sum     <= '0;
          r_is_csum <= 1'b0;
`endif
          r_state   <= S_SEND;
        end

        // mem_addr was loaded on entry, so mem_q is valid at the edge
        // ending the RD_LAT-th FETCH cycle.
        S_FETCH: begin
          r_mem_addr <= r_idx[ADDR_W-1:0];
          if (r_fcnt == FETCH_LAST) begin
            r_tx_byte <= mem_q;
`ifdef CUBE_STREAM_CHECKSUM_EN
            r_sum     <= r_sum + mem_q;
`endif
            r_state   <= S_SEND;
          end else begin
            r_fcnt <= r_fcnt + 2'd1;
          end
        end

        S_SEND: begin
          if (!tx_busy) begin
            r_tx_start <= 1'b1;
            r_wait     <= '0;
            r_retried  <= 1'b0;
            r_state    <= S_ACK;
          end
        end

        // A UART that never raises busy gets one re-issued request after
        // four idle cycles; after that we simply keep waiting.
        S_ACK: begin
          if (tx_busy) begin
            r_state <= S_DRAIN;
          end else if (!r_retried) begin
            r_wait <= r_wait + 2'd1;
            if (r_wait == 2'd3) begin
              r_tx_start <= 1'b1;
              r_retried  <= 1'b1;
            end
          end
        end

        S_DRAIN: begin
          if (!tx_busy) begin
            if (r_is_hdr) begin
              r_is_hdr   <= 1'b0;
              r_idx      <= '0;
              r_mem_addr <= '0;
              r_fcnt     <= '0;
              r_state    <= S_FETCH;
            end else if (r_idx != LAST_IDX) begin
              r_idx      <= w_idx_inc;
              r_mem_addr <= w_idx_inc[ADDR_W-1:0];
              r_fcnt     <= '0;
              r_state    <= S_FETCH;
            end
`ifdef CUBE_STREAM_CHECKSUM_EN
            else if (!r_is_csum) begin
              r_state <= S_CSUM;
            end
`endif
            else begin
              r_done      <= 1'b1;
              r_frame_cnt <= r_frame_cnt + 16'd1;
              r_state     <= S_DONE;
            end
          end
        end

`ifdef CUBE_STREAM_CHECKSUM_EN
        S_CSUM: begin
          r_tx_byte <= r_sum;
          r_is_csum <= 1'b1;
          r_state   <= S_SEND;
        end
`endif

        S_DONE: begin
          r_busy  <= continuous;
          r_state <= continuous ? S_HDR : S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_addr  = r_mem_addr;
  assign tx_start  = r_tx_start;
  assign tx_byte   = r_tx_byte;
  assign busy      = r_busy;
  assign done      = r_done;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_cube_frame_streamer.sv
`timescale 1ns/1ps
// Bench for cube_frame_streamer: two instances (64-byte/latency-1 and
// 4-byte/latency-3), behavioural RAM and UART models, byte-stream scoreboard.
module tb_cube_frame_streamer;
  typedef logic [7:0] bq_t[$];

  localparam int DA = 64;
  localparam int DB = 4;
  localparam logic [7:0] SYNC = 8'hF0;
`ifdef CUBE_STREAM_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int FA = DA + 1 + EXTRA;
  localparam int FB = DB + 1 + EXTRA;

  logic clock;
  logic resetn;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- instance A: DEPTH 64, RD_LAT 1 ----------------
  logic       start_a, cont_a, tx_busy_a, tx_start_a, busy_a, done_a;
  logic [5:0] mem_addr_a;
  logic [7:0] mem_q_a, tx_byte_a;
  logic [15:0] frame_cnt_a;
  logic [7:0] ram_a [DA];

  cube_frame_streamer #(.DEPTH(DA), .ADDR_W(6), .RD_LAT(1), .SYNC_BYTE(SYNC)) u_a (
    .clock(clock), .resetn(resetn), .start(start_a), .continuous(cont_a),
    .mem_addr(mem_addr_a), .mem_q(mem_q_a), .tx_start(tx_start_a),
    .tx_byte(tx_byte_a), .tx_busy(tx_busy_a), .busy(busy_a), .done(done_a),
    .frame_cnt(frame_cnt_a));

  assign mem_q_a = ram_a[mem_addr_a];

  // ---------------- instance B: DEPTH 4, RD_LAT 3 ----------------
  logic       start_b, cont_b, tx_busy_b, tx_start_b, busy_b, done_b;
  logic [1:0] mem_addr_b, ad1_b, ad2_b;
  logic [7:0] mem_q_b, tx_byte_b;
  logic [15:0] frame_cnt_b;
  logic [7:0] ram_b [DB];

  cube_frame_streamer #(.DEPTH(DB), .ADDR_W(2), .RD_LAT(3), .SYNC_BYTE(SYNC)) u_b (
    .clock(clock), .resetn(resetn), .start(start_b), .continuous(cont_b),
    .mem_addr(mem_addr_b), .mem_q(mem_q_b), .tx_start(tx_start_b),
    .tx_byte(tx_byte_b), .tx_busy(tx_busy_b), .busy(busy_b), .done(done_b),
    .frame_cnt(frame_cnt_b));

  // RAM with two address pipeline stages: data valid 3 clocks after address.
  always @(posedge clock) begin
    ad1_b <= mem_addr_b;
    ad2_b <= ad1_b;
  end
  assign mem_q_b = ram_b[ad2_b];

  // ---------------- UART models (sampled on the falling edge) ----------------
  int   bcnt_a, bcnt_b, pulses_a, pulses_b, done_n_a, done_n_b, viol_a, viol_b;
  int   ign_req_a, ign_done_a;
  logic hold_a;
  logic prev_start_a, prev_done_a, prev_start_b, prev_done_b;
  logic [7:0] held_a, held_b;
  bq_t  rxq_a, rxq_b;
  int   tq_a[$];
  int   dsnap_a[$];

  assign tx_busy_a = hold_a | (bcnt_a != 0);
  assign tx_busy_b = (bcnt_b != 0);

  always @(negedge clock) begin
    prev_start_a <= tx_start_a;
    prev_done_a  <= done_a;
    if (done_a) begin
      done_n_a <= done_n_a + 1;
      dsnap_a.push_back(rxq_a.size());
      if (prev_done_a) viol_a <= viol_a + 1;
    end
    if (tx_start_a) begin
      pulses_a <= pulses_a + 1;
      tq_a.push_back(cyc);
      if (prev_start_a || tx_busy_a) viol_a <= viol_a + 1;
      if (ign_req_a != ign_done_a) begin
        ign_done_a <= ign_done_a + 1;
      end else begin
        rxq_a.push_back(tx_byte_a);
        held_a <= tx_byte_a;
        bcnt_a <= int'($urandom_range(12, 1));
      end
    end else if (bcnt_a != 0) begin
      if (resetn && (tx_byte_a !== held_a)) viol_a <= viol_a + 1;
      bcnt_a <= bcnt_a - 1;
    end
  end

  always @(negedge clock) begin
    prev_start_b <= tx_start_b;
    prev_done_b  <= done_b;
    if (done_b) begin
      done_n_b <= done_n_b + 1;
      if (prev_done_b) viol_b <= viol_b + 1;
    end
    if (tx_start_b) begin
      pulses_b <= pulses_b + 1;
      if (prev_start_b || tx_busy_b) viol_b <= viol_b + 1;
      rxq_b.push_back(tx_byte_b);
      held_b <= tx_byte_b;
      bcnt_b <= int'($urandom_range(9, 1));
    end else if (bcnt_b != 0) begin
      if (resetn && (tx_byte_b !== held_b)) viol_b <= viol_b + 1;
      bcnt_b <= bcnt_b - 1;
    end
  end

  // ---------------- reference model and checking helpers ----------------
  int tests, fails;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected wire image of one frame: header, data in address order, and
  // (when built in) the modulo-256 sum of the data.
  function automatic bq_t frame_of(input bq_t img);
    bq_t r;
`ifdef CUBE_STREAM_CHECKSUM_EN
    int sum;
    sum = 0;
`endif
    r.push_back(SYNC);
    foreach (img[i]) begin
      r.push_back(img[i]);
`ifdef CUBE_STREAM_CHECKSUM_EN
      sum += int'(img[i]);
`endif
    end
`ifdef CUBE_STREAM_CHECKSUM_EN
    r.push_back(8'(sum % 256));
`endif
    return r;
  endfunction

  function automatic bq_t img_of(input int w);
    bq_t r;
    if (w == 0) for (int i = 0; i < DA; i++) r.push_back(ram_a[i]);
    else        for (int i = 0; i < DB; i++) r.push_back(ram_b[i]);
    return r;
  endfunction

  function automatic bq_t rx_from(input int w, input int base);
    bq_t r;
    if (w == 0) for (int i = base; i < rxq_a.size(); i++) r.push_back(rxq_a[i]);
    else        for (int i = base; i < rxq_b.size(); i++) r.push_back(rxq_b[i]);
    return r;
  endfunction

  task automatic cmp_stream(input string tag, input bq_t got, input bq_t exp);
    chk({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s[%0d]", tag, i),
          (i < got.size()) ? {24'h0, got[i]} : 32'hFFFF_FFFF, {24'h0, exp[i]});
  endtask

  task automatic pulse_start(input int w);
    @(negedge clock);
    if (w == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge clock);
    if (w == 0) start_a = 1'b0; else start_b = 1'b0;
  endtask

  task automatic wait_done(input int w, input int n, input string tag);
    int k;
    k = 0;
    while (((w == 0) ? done_n_a : done_n_b) < n && k < 20000) begin
      @(posedge clock);
      k++;
    end
    chk(tag, (((w == 0) ? done_n_a : done_n_b) >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic do_reset(input int n);
    @(negedge clock);
    resetn = 1'b0;
    repeat (n) @(negedge clock);
    resetn = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  int base, p0, d0, k;
  bq_t e1, e3;

  initial begin
    resetn = 1'b0;
    start_a = 1'b0; cont_a = 1'b0; hold_a = 1'b0;
    start_b = 1'b0; cont_b = 1'b0;
    for (int i = 0; i < DA; i++) ram_a[i] = 8'(i);
    ram_b[0] = 8'hAA; ram_b[1] = 8'h55; ram_b[2] = 8'h0F; ram_b[3] = 8'hF0;

    repeat (4) @(posedge clock);
    #1;
    chk("rst_mem_addr", {26'h0, mem_addr_a}, 32'h0);
    chk("rst_tx_start", {31'h0, tx_start_a}, 32'h0);
    chk("rst_tx_byte",  {24'h0, tx_byte_a}, 32'h0);
    chk("rst_busy",     {31'h0, busy_a}, 32'h0);
    chk("rst_done",     {31'h0, done_a}, 32'h0);
    chk("rst_frame_cnt", {16'h0, frame_cnt_a}, 32'h0);
    chk("rst_busy_b",   {31'h0, busy_b}, 32'h0);
    @(negedge clock);
    resetn = 1'b1;

    // Basic frame, RAM[i] = i
    base = rxq_a.size(); p0 = pulses_a; d0 = done_n_a;
    pulse_start(0);
    wait_done(0, d0 + 1, "basic_done_timeout");
    repeat (20) @(posedge clock);
    #1;
    cmp_stream("basic", rx_from(0, base), frame_of(img_of(0)));
    chk("basic_pulses", pulses_a - p0, FA);
    chk("basic_done_cnt", done_n_a - d0, 1);
    chk("basic_done_after_last", dsnap_a[d0], base + FA);
    chk("basic_frame_cnt", {16'h0, frame_cnt_a}, 32'd1);
    chk("basic_busy_after", {31'h0, busy_a}, 32'h0);
    chk("basic_addr_hold", {26'h0, mem_addr_a}, 32'd63);
`ifdef CUBE_STREAM_CHECKSUM_EN
    chk("basic_csum_E0", {24'h0, rxq_a[base + DA + 1]}, 32'hE0);
`endif

    // Continuous mode, random frame contents, drop continuous in frame 3
    do_reset(2);
    #1;
    chk("cont_frame_cnt_rst", {16'h0, frame_cnt_a}, 32'h0);
    for (int i = 0; i < DA; i++) ram_a[i] = 8'($urandom);
    base = rxq_a.size(); p0 = pulses_a; d0 = done_n_a;
    cont_a = 1'b1;
    pulse_start(0);
    wait_done(0, d0 + 2, "cont_done2_timeout");
    repeat (5) @(negedge clock);
    chk("cont_busy_in_f3", {31'h0, busy_a}, 32'h1);
    cont_a = 1'b0;
    wait_done(0, d0 + 3, "cont_done3_timeout");
    repeat (60) @(posedge clock);
    #1;
    e1 = frame_of(img_of(0));
    e3 = {};
    for (int f = 0; f < 3; f++) foreach (e1[i]) e3.push_back(e1[i]);
    cmp_stream("cont", rx_from(0, base), e3);
    chk("cont_pulses", pulses_a - p0, 3 * FA);
    chk("cont_done_cnt", done_n_a - d0, 3);
    chk("cont_frame_cnt", {16'h0, frame_cnt_a}, 32'd3);
    chk("cont_busy_after", {31'h0, busy_a}, 32'h0);

    // UART stalled before the header, then first request ignored
    for (int i = 0; i < DA; i++) ram_a[i] = 8'($urandom);
    hold_a = 1'b1;
    base = rxq_a.size(); p0 = pulses_a; d0 = done_n_a;
    pulse_start(0);
    repeat (50) @(posedge clock);
    #1;
    chk("stall_no_pulse", pulses_a - p0, 0);
    chk("stall_busy", {31'h0, busy_a}, 32'h1);
    @(negedge clock);
    ign_req_a = ign_req_a + 1;
    hold_a = 1'b0;
    wait_done(0, d0 + 1, "retry_done_timeout");
    repeat (20) @(posedge clock);
    #1;
    cmp_stream("retry", rx_from(0, base), frame_of(img_of(0)));
    chk("retry_pulses", pulses_a - p0, FA + 1);
    chk("retry_gap", tq_a[p0 + 1] - tq_a[p0], 4);
    chk("retry_frame_cnt", {16'h0, frame_cnt_a}, 32'd4);

    // Reset mid-frame after the 10th byte
    base = rxq_a.size();
    pulse_start(0);
    k = 0;
    while (rxq_a.size() < base + 10 && k < 5000) begin
      @(posedge clock);
      k++;
    end
    chk("mid_reach10_timeout", (rxq_a.size() >= base + 10) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clock);
    resetn = 1'b0;
    @(posedge clock);
    #1;
    chk("mid_mem_addr", {26'h0, mem_addr_a}, 32'h0);
    chk("mid_tx_start", {31'h0, tx_start_a}, 32'h0);
    chk("mid_tx_byte",  {24'h0, tx_byte_a}, 32'h0);
    chk("mid_busy",     {31'h0, busy_a}, 32'h0);
    chk("mid_done",     {31'h0, done_a}, 32'h0);
    chk("mid_frame_cnt", {16'h0, frame_cnt_a}, 32'h0);
    p0 = pulses_a;
    repeat (15) @(negedge clock);
    resetn = 1'b1;
    repeat (60) @(posedge clock);
    #1;
    chk("mid_no_pulse_after", pulses_a - p0, 0);
    chk("mid_bytes_sent", rxq_a.size() - base, 10);
    chk("mid_busy_after", {31'h0, busy_a}, 32'h0);

    // Parameter sweep instance: {AA,55,0F,F0} then random contents
    base = rxq_b.size(); p0 = pulses_b; d0 = done_n_b;
    pulse_start(1);
    wait_done(1, d0 + 1, "sweep_done_timeout");
    repeat (20) @(posedge clock);
    #1;
    cmp_stream("sweep", rx_from(1, base), frame_of(img_of(1)));
    chk("sweep_byte1_AA", {24'h0, rxq_b[base + 1]}, 32'hAA);
    chk("sweep_pulses", pulses_b - p0, FB);
    chk("sweep_frame_cnt", {16'h0, frame_cnt_b}, 32'd1);
    for (int i = 0; i < DB; i++) ram_b[i] = 8'($urandom);
    base = rxq_b.size(); d0 = done_n_b;
    pulse_start(1);
    wait_done(1, d0 + 1, "sweep2_done_timeout");
    repeat (20) @(posedge clock);
    #1;
    cmp_stream("sweep2", rx_from(1, base), frame_of(img_of(1)));
    chk("sweep2_frame_cnt", {16'h0, frame_cnt_b}, 32'd2);
    chk("sweep_busy_after", {31'h0, busy_b}, 32'h0);

    chk("a_protocol_violations", viol_a, 0);
    chk("b_protocol_violations", viol_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
